// File: rtl/ps2kbd_io.sv
// Host-side PS/2 keyboard receiver with scan-code FIFO, memory-mapped as STATUS (BASE) and DATA (BASE+1).
// Optional: define PS2KBD_PARITY_EN to enforce odd parity and report PERR.
module ps2kbd_io #(
  parameter logic [15:0] BASE       = 16'h0030,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FILTER     = 4,
  parameter int          TIMEOUT    = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_i,
  input  logic        wren,
  output logic [7:0]  data_o,
  output logic        sel,
  input  logic        ps2_clk,
  input  logic        ps2_dat
);
  // state    | meaning
  // S_IDLE   | waiting for a start bit (data low at a sample point)
  // S_DATA   | shifting 8 data bits, LSB first
  // S_PARITY | capturing the parity bit
  // S_STOP   | checking the stop bit, pushing the byte if good
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = $clog2(FILTER) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FC_MAX = FCW'(FILTER - 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [CW-1:0]  C_FULL = CW'(FIFO_DEPTH);

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           fclk_q, fclk_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d, perr_q, perr_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
`ifdef PS2KBD_PARITY_EN
  logic           par_q, par_d;
`endif

  logic sel_status, sel_data, empty, full, sample, pop, push, push_ok, perr_set, st_wr;
  logic [7:0] status;
  logic unused_data;

  assign unused_data = ^{data_i[7:4], data_i[1:0]};

  always_comb begin
    fclk_d    = fclk_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    wdog_d    = wdog_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    push      = 1'b0;
    perr_set  = 1'b0;
`ifdef PS2KBD_PARITY_EN
    par_d     = par_q;
`endif

    sel_status = (address == BASE);
    sel_data   = (address == BASE + 16'd1);
    sel        = sel_status | sel_data;
    empty      = (count_q == '0);
    full       = (count_q == C_FULL);
    pop        = wren & sel_data & ~empty;
    st_wr      = wren & sel_status;

    // Clock level flips only after FILTER consecutive disagreeing samples.
    sample = fclk_q & ~clk_s2_q & (fcnt_q == FC_MAX);
    if (clk_s2_q == fclk_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FC_MAX) begin
      fclk_d = ~fclk_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (sample && !dat_s2_q) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: if (sample) begin
        shreg_d  = {dat_s2_q, shreg_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (sample) begin
`ifdef PS2KBD_PARITY_EN
        par_d   = dat_s2_q;
`endif
        state_d = S_STOP;
      end
      default: if (sample) begin
        state_d = S_IDLE;
        if (dat_s2_q) begin
`ifdef PS2KBD_PARITY_EN
          if (^{par_q, shreg_q}) push = 1'b1;
          else                   perr_set = 1'b1;
`else
          push = 1'b1;
`endif
        end
      end
    endcase

    if (state_q != S_IDLE) begin
      if (sample) begin
        wdog_d = '0;
      end else if (wdog_q == WD_MAX) begin
        state_d = S_IDLE;
        wdog_d  = '0;
      end else begin
        wdog_d = wdog_q + WDW'(1);
      end
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push_ok = push & (~full | pop);
    if (push_ok) tail_d = tail_q + PW'(1);
    if (pop)     head_d = head_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);

    ovf_d  = (ovf_q  & ~(st_wr & data_i[2])) | (push & full & ~pop);
    perr_d = (perr_q & ~(st_wr & data_i[3])) | perr_set;

    status = {4'(count_q), perr_q, ovf_q, full, ~empty};
    data_o = 8'h00;
    if (sel_status)          data_o = status;
    else if (sel_data && !empty) data_o = mem_q[head_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fclk_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      wdog_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
`ifdef PS2KBD_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
      fclk_q   <= fclk_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      wdog_q   <= wdog_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
`ifdef PS2KBD_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[tail_q] <= shreg_q;
  end
endmodule

// File: doc/ps2kbd_io.md
# ps2kbd_io

Host-side PS/2 keyboard receiver with a scan-code FIFO, exposed to the AVR core as a memory-mapped responder on its data bus. It decodes device-to-host frames from the PS2_CLK/PS2_DAT pins, buffers the bytes, and answers CPU reads and writes to two registers. In the top level, its `data_o` is routed into the CPU `data_i` whenever `sel` is high. It is clocked from the CPU clock domain (25 MHz).

## Interface
- `BASE`, 16'h0030, address of STATUS; DATA is at BASE+1
- `FIFO_DEPTH`, 8, FIFO entries; legal values are 2, 4 or 8
- `FILTER`, 4, consecutive equal samples needed to accept a PS/2 clock level
- `TIMEOUT`, 25000, cycles without a PS/2 falling edge before a partial frame is abandoned
- `clock`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `address`  in  16  CPU data address
- `data_i`  in  8  CPU write data
- `wren`  in  1  CPU write strobe
- `data_o`  out  8  read data; combinational
- `sel`  out  1  high when `address` is BASE or BASE+1; combinational
- `ps2_clk`  in  1  raw asynchronous PS/2 clock
- `ps2_dat`  in  1  raw asynchronous PS/2 data

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_dat` each pass through a 2-flop synchronizer.
  - Filtered clock: starts at 1. It changes level only after FILTER consecutive synchronized samples at the new level.
  - A falling edge of the filtered clock is the sample point for the synchronized data line.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP), acting on sample points:
  - IDLE: data=0 moves to DATA with bitcnt=0. Data=1 is ignored.
  - DATA: shift the bit into `shreg` LSB-first. After the 8th bit, move to PARITY.
  - PARITY: latch the parity bit, move to STOP.
  - STOP: return to IDLE. Push `shreg` if the stop bit is 1 and parity is accepted (see Configuration). A stop bit of 0 drops the frame with no flag.
  - Watchdog: in any state except IDLE, a cycle counter is cleared at each sample point. When it reaches TIMEOUT, the FSM goes to IDLE and the partial byte is discarded. The counter is held at 0 in IDLE.
- **FIFO**: circular buffer with head/tail pointers and a count of width log2(FIFO_DEPTH)+1.
  - Push when full: byte dropped, OVF set. Exception: if a pop happens in the same cycle, the push is accepted.
  - Push and pop in the same cycle with count > 0: both take effect, count unchanged.
  - Pop when empty: no effect.
- **Registers**
  - STATUS read: bit0 not-empty, bit1 full, bit2 OVF (sticky), bit3 PERR (sticky), bits7:4 count.
  - STATUS write: writing 1 to bit2 clears OVF; writing 1 to bit3 clears PERR; other bits are ignored. If a set and a clear hit the same cycle, the set wins.
  - DATA read: head byte, or 0x00 when empty. Reading has no side effect.
  - DATA write (any value): pop.
  - `data_o` is 0x00 when `sel` is low.
- **Reset**: FSM to IDLE, FIFO empty, OVF/PERR cleared, filtered clock set to 1, synchronizers set to 1, watchdog set to 0. Reset during a frame abandons the frame.

## Timing
- `data_o` and `sel` are zero-latency (combinational) from `address` and the registered state.
- A write takes effect on the clock edge with `wren`=1. The new STATUS/DATA values are visible the following cycle.
- Push latency: the byte is visible no more than 2+FILTER+2 cycles after the raw `ps2_clk` falls on the stop bit.
- Minimum supported PS/2 half-period is FILTER+4 cycles. Standard PS/2 timing (30-50 µs half-period) is met at 25 MHz.

## Configuration
- `PS2KBD_PARITY_EN` defined:
  - Odd parity is checked over the 8 data bits plus the parity bit.
  - On a mismatch, the frame is dropped and PERR is set.
- Undefined:
  - The parity bit is sampled and ignored.
  - PERR is never set and always reads 0.

## Test plan
- **Reset state**: assert `reset` for 2 cycles, read BASE and BASE+1 -> both 0x00; `sel`=1 at BASE, BASE+1 and 0 at BASE+2.
- **Single byte**: send a valid frame 0x1C (parity 0) -> STATUS=0x11, DATA=0x1C; write DATA -> STATUS=0x00.
- **Overflow**: send 9 valid bytes 0x01..0x09 with no pops -> STATUS=0x87, DATA=0x01; write 0x04 to STATUS -> 0x83; 8 pops return 0x01..0x08, then STATUS=0x00.
- **Parity error**: send 0x1C with parity bit 1 -> with the macro, STATUS=0x08 and FIFO empty; without the macro, STATUS=0x11 and DATA=0x1C.
- **Watchdog**: send a start bit plus 3 data bits, idle TIMEOUT+10 cycles, then a valid frame 0xF0 -> STATUS=0x11, DATA=0xF0.
- **Glitch and full-edge push**:
  - A `ps2_clk` low pulse of FILTER-1 cycles in IDLE -> no state change.
  - With FIFO full, pop on the exact cycle a byte is pushed -> count stays 8 and OVF stays 0.
